// File: rtl/interrupt_controller_if.sv
// interrupt_controller_if: interrupt/ack handshake between the interrupt controller (master) and the processor (slave).
interface interrupt_controller_if;
    logic        interrupt;
    logic [3:0]  irq_id;
    logic [15:0] irq_vector;
    logic        in_service;
    logic        ack;
    logic        reti;
    modport master (output interrupt, irq_id, irq_vector, in_service, input ack, reti);
    modport slave  (input interrupt, irq_id, irq_vector, in_service, output ack, reti);
endinterface

// File: rtl/interrupt_controller.sv
// interrupt_controller: latches rising-edge events, requests the highest-priority unmasked one and tracks its ISR.
module interrupt_controller #(
    parameter int          NUM_SRC    = 4,
    parameter logic [15:0] VEC_BASE   = 16'h0010,
    parameter logic [15:0] VEC_STRIDE = 16'h0002
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_SRC-1:0]  irq_src,
    input  logic                mask_we,
    input  logic [NUM_SRC-1:0]  mask_wdata,
    output logic [NUM_SRC-1:0]  pending,
    output logic                overrun,
    interrupt_controller_if.master bus
);
    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
    state_t               state;
    logic [NUM_SRC-1:0]   src_q, mask, edge_det, clr, eligible;
    logic [3:0]           win;
    logic [15:0]          win_vec;
    assign edge_det = irq_src & ~src_q;
    assign clr      = (state == REQ && bus.ack) ? {{(NUM_SRC-1){1'b0}}, 1'b1} << bus.irq_id : '0;
    assign eligible = pending & ~mask;
    assign win_vec  = VEC_BASE + 16'(win) * VEC_STRIDE;
    always_comb begin
        win = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--)
            if (eligible[i]) win = 4'(i);
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            src_q          <= '0;
            mask           <= '0;
            pending        <= '0;
            overrun        <= 1'b0;
            bus.interrupt  <= 1'b0;
            bus.irq_id     <= '0;
            bus.irq_vector <= VEC_BASE;
            bus.in_service <= 1'b0;
        end else begin
            src_q   <= irq_src;
            if (mask_we) mask <= mask_wdata;
            // a new edge outranks the ack clear, so the event is kept rather than reported as overrun
            pending <= (pending & ~clr) | edge_det;
            overrun <= |(edge_det & pending & ~clr);
            case (state)
                IDLE: if (|eligible) begin
                    bus.interrupt  <= 1'b1;
                    bus.irq_id     <= win;
                    bus.irq_vector <= win_vec;
                    state          <= REQ;
                end
                REQ: if (bus.ack) begin
                    bus.interrupt  <= 1'b0;
                    bus.in_service <= 1'b1;
                    state          <= SERVICE;
                end
                SERVICE: if (bus.reti) begin
                    bus.in_service <= 1'b0;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_interrupt_controller.sv
// tb_interrupt_controller: directed vectors with hand-computed expectations for interrupt_controller.
module tb_interrupt_controller;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] irq_src = '0;
    logic       mask_we = 1'b0;
    logic [3:0] mask_wdata = '0;
    logic [3:0] pending;
    logic       overrun;
    int         n_chk = 0;
    int         n_fail = 0;
    interrupt_controller_if bus ();
    interrupt_controller dut (
        .clk(clk), .rst(rst), .irq_src(irq_src), .mask_we(mask_we),
        .mask_wdata(mask_wdata), .pending(pending), .overrun(overrun), .bus(bus.master)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    initial begin
        bus.ack  = 1'b0;
        bus.reti = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("rst_int", 32'(bus.interrupt), 0);
        chk("rst_id", 32'(bus.irq_id), 0);
        chk("rst_vec", 32'(bus.irq_vector), 32'h0010);
        chk("rst_pend", 32'(pending), 0);
        chk("rst_isv", 32'(bus.in_service), 0);
        chk("rst_ovr", 32'(overrun), 0);
        bus.ack = 1'b1; bus.reti = 1'b1;
        tick();
        bus.ack = 1'b0; bus.reti = 1'b0;
        tick();
        chk("idle_ack_int", 32'(bus.interrupt), 0);
        chk("idle_ack_isv", 32'(bus.in_service), 0);
        // single source 2
        irq_src = 4'b0100;
        tick();
        chk("s2_pend", 32'(pending), 4'b0100);
        chk("s2_int_n", 32'(bus.interrupt), 0);
        tick();
        chk("s2_int", 32'(bus.interrupt), 1);
        chk("s2_id", 32'(bus.irq_id), 2);
        chk("s2_vec", 32'(bus.irq_vector), 32'h0014);
        bus.ack = 1'b1;
        tick();
        chk("s2_ack_int", 32'(bus.interrupt), 0);
        chk("s2_ack_pend", 32'(pending), 0);
        chk("s2_ack_isv", 32'(bus.in_service), 1);
        bus.ack = 1'b0; bus.reti = 1'b1;
        tick();
        chk("s2_reti_isv", 32'(bus.in_service), 0);
        bus.reti = 1'b0; irq_src = 4'b0000;
        tick();
        chk("s2_idle_int", 32'(bus.interrupt), 0);
        // simultaneous src1 and src3
        irq_src = 4'b1010;
        tick();
        chk("pri_pend", 32'(pending), 4'b1010);
        irq_src = 4'b0000;
        tick();
        chk("pri_int", 32'(bus.interrupt), 1);
        chk("pri_id1", 32'(bus.irq_id), 1);
        chk("pri_vec1", 32'(bus.irq_vector), 32'h0012);
        bus.ack = 1'b1;
        tick();
        chk("pri_pend3", 32'(pending), 4'b1000);
        bus.ack = 1'b0; bus.reti = 1'b1;
        tick();
        bus.reti = 1'b0;
        chk("pri_gap_int", 32'(bus.interrupt), 0);
        tick();
        chk("pri_int3", 32'(bus.interrupt), 1);
        chk("pri_id3", 32'(bus.irq_id), 3);
        chk("pri_vec3", 32'(bus.irq_vector), 32'h0016);
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0; bus.reti = 1'b1;
        tick();
        bus.reti = 1'b0;
        chk("pri_done_pend", 32'(pending), 0);
        // mask
        mask_we = 1'b1; mask_wdata = 4'b0001; irq_src = 4'b0001;
        tick();
        chk("msk_pend", 32'(pending), 4'b0001);
        mask_we = 1'b0; irq_src = 4'b0000;
        tick();
        chk("msk_int0a", 32'(bus.interrupt), 0);
        tick();
        chk("msk_int0b", 32'(bus.interrupt), 0);
        mask_we = 1'b1; mask_wdata = 4'b0000;
        tick();
        chk("msk_oldmask", 32'(bus.interrupt), 0);
        mask_we = 1'b0;
        tick();
        chk("msk_int", 32'(bus.interrupt), 1);
        chk("msk_id", 32'(bus.irq_id), 0);
        chk("msk_vec", 32'(bus.irq_vector), 32'h0010);
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0; bus.reti = 1'b1;
        tick();
        bus.reti = 1'b0;
        // overrun
        irq_src = 4'b0100;
        tick();
        chk("ovr_first", 32'(overrun), 0);
        irq_src = 4'b0000;
        tick();
        chk("ovr_int", 32'(bus.interrupt), 1);
        irq_src = 4'b0100;
        tick();
        chk("ovr_pulse", 32'(overrun), 1);
        chk("ovr_keep_id", 32'(bus.irq_id), 2);
        irq_src = 4'b0000;
        tick();
        chk("ovr_end", 32'(overrun), 0);
        irq_src = 4'b0100; bus.ack = 1'b1;
        tick();
        chk("ack_edge_pend", 32'(pending), 4'b0100);
        chk("ack_edge_ovr", 32'(overrun), 0);
        chk("ack_edge_isv", 32'(bus.in_service), 1);
        irq_src = 4'b0000; bus.ack = 1'b0; bus.reti = 1'b1;
        tick();
        bus.reti = 1'b0;
        tick();
        chk("rereq_int", 32'(bus.interrupt), 1);
        chk("rereq_id", 32'(bus.irq_id), 2);
        // async reset mid-REQ
        #2 rst = 1'b0;
        #1;
        chk("arst_int", 32'(bus.interrupt), 0);
        chk("arst_pend", 32'(pending), 0);
        tick();
        rst = 1'b1;
        tick();
        tick();
        chk("arst_noreq", 32'(bus.interrupt), 0);
        chk("arst_isv", 32'(bus.in_service), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
